pe_array_ctrl: RTL and testbench
================================

# pe_array_ctrl

Sequencer that runs one dot-product pass on the 2×16 PE array. On `start` it reads `k_len` input rows and weight pairs from the operand buffers and presents each pair to the array on the next cycle. It drives `add_number`, `keep` and `rounder_en` in step with that data, then waits for the array's `rounder_valid` and reports completion. It sits between the operand buffers and `pe_array`.

## Interface
- `K_MAX`, 16: maximum reduction length; buffer address width `AW = $clog2(K_MAX)`.
- `ROUND_LAT`, 3: cycles from the array seeing `rounder_en` high to `rounder_valid` high.
- `TMO`, 4: extra DRAIN cycles allowed beyond `ROUND_LAT` before a timeout error.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `k_len`  in  $clog2(K_MAX+1)  reduction length, sampled with `start`.
- `acc_sel`  in  3  accumulator register index, sampled with `start`.
- `src_valid`  in  1  operand buffers can deliver this cycle.
- `rounder_valid`  in  1  from `pe_array`.
- `rd_en`  out  1  combinational read strobe to the input and weight buffers.
- `rd_addr`  out  AW  combinational beat index 0..k_len-1.
- `add_number`  out  3  to `pe_array`, registered.
- `keep`  out  1  to `pe_array`, registered; 1 = hold accumulators.
- `rounder_en`  out  1  to `pe_array`, registered.
- `busy`  out  1  high in every state except IDLE.
- `result_valid`  out  1  one-cycle pulse when `rounder_valid` is seen in DRAIN.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  qualifies `done`: 1 = timeout; 0 otherwise.

## Operation
- States: IDLE, FEED, DRAIN, DONE.
- **IDLE**
  - `start` with `k_len` ≥ 1 → FEED; latch `k_len` and `acc_sel`; clear the beat counter.
  - `start` with `k_len` = 0 → DONE directly, `err` = 0; no reads; `rounder_en` stays 0.
- **FEED**
  - `rd_en = src_valid`; `rd_addr` = beat counter.
  - Counter increments only when `rd_en` = 1.
  - After the read with `rd_addr` = `k_len`-1 → DRAIN.
- **Array-side pipeline** (1-cycle buffer read latency)
  - Register `rd_en` into `beat_vld`.
  - Next cycle: `keep = !beat_vld` while FEED or the final beat is outstanding; `keep` = 1 in all other states.
  - `add_number` = latched `acc_sel` while the pass is active; 0 otherwise.
  - `rounder_en` = 1 only on the cycle the last beat reaches the array.
- **DRAIN**
  - Wait counter starts when the array sees `rounder_en`.
  - `rounder_valid` = 1 → pulse `result_valid`, go to DONE with `err` = 0.
  - Counter reaches `ROUND_LAT`+`TMO` → DONE with `err` = 1.
  - `rounder_valid` seen in any other state is ignored.
- **DONE**
  - `done` = 1 for one cycle; `err` is valid on that cycle; then IDLE.
- `start` while `busy` = 1 is ignored; no queuing.
- Reset, including mid-pass: immediate return to IDLE.
  - Reset values: `rd_en`, `rd_addr`, `add_number`, `rounder_en`, `busy`, `result_valid`, `done`, `err` = 0; `keep` = 1.
  - After reset, `keep` stays 1 until the next pass, so the accumulators are not disturbed.
- `src_valid` does not affect anything outside FEED.

## Timing
- Cycle 0: `start` sampled.
- Cycles 1..k_len: reads issued, assuming no stalls.
- Cycles 2..k_len+1: array beats with `keep` = 0; `rounder_en` = 1 on cycle k_len+1.
- Expected `rounder_valid` on cycle k_len+1+ROUND_LAT; `result_valid` on that same cycle; `done` on the next cycle.
- Each cycle of `src_valid` = 0 in FEED adds exactly one cycle to every later event and produces exactly one `keep` = 1 bubble.
- Minimum `start`-to-`done`: k_len+2+ROUND_LAT cycles; k_len = 0 gives `done` on cycle 1.
- Registered outputs change only on `clk` rising edges; the `rst_n` assertion edge is the exception.

## Test plan
- **Basic pass:** k_len=4, acc_sel=5, `src_valid`=1, `rounder_valid` at cycle 8.
  - Required: `rd_addr` 0,1,2,3 on cycles 1–4.
  - Required: `keep`=0 and `add_number`=5 on cycles 2–5; `rounder_en` only on cycle 5.
  - Required: `result_valid` on cycle 8; `done`=1, `err`=0 on cycle 9.
- **Stall:** k_len=3, `src_valid`=0 on cycle 2.
  - Required: addr 0 on cycle 1, addr 1 on cycles 2–3, addr 2 on cycle 4.
  - Required: `keep`=1 only on cycle 3; `rounder_en` on cycle 5.
- **Zero length:** `start` with k_len=0.
  - Required: `done`=1, `err`=0 on cycle 1; no `rd_en`, no `rounder_en`, `keep` stays 1.
- **Busy start:** second `start` with k_len=2 at cycle 3 of a k_len=4 pass.
  - Required: ignored; the pass completes exactly as in the basic case; exactly one `done`.
- **Timeout:** k_len=2, `rounder_valid` held 0.
  - Required: `done`=1, `err`=1 on cycle 3+ROUND_LAT+TMO+1; no `result_valid`.
- **Reset mid-FEED:** `rst_n`=0 during cycle 2 of a k_len=8 pass.
  - Required: all outputs immediately at their reset values, `keep`=1.
  - Required: after release, a new k_len=1 pass runs normally.

Source files
------------

// File: rtl/pe_array_ctrl_if.sv
// Bundles the pe_array_ctrl command, operand-buffer and PE-array signals.
// master: the side that issues passes and drives the buffers/array inputs.
// slave: the controller itself.
interface pe_array_ctrl_if #(
    parameter int K_MAX = 16
);
    localparam int AW = $clog2(K_MAX);
    localparam int KW = $clog2(K_MAX + 1);

    logic          start;
    logic [KW-1:0] k_len;
    logic [2:0]    acc_sel;
    logic          src_valid;
    logic          rounder_valid;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [2:0]    add_number;
    logic          keep;
    logic          rounder_en;
    logic          busy;
    logic          result_valid;
    logic          done;
    logic          err;

    modport master (
        output start, k_len, acc_sel, src_valid, rounder_valid,
        input  rd_en, rd_addr, add_number, keep, rounder_en,
               busy, result_valid, done, err
    );

    modport slave (
        input  start, k_len, acc_sel, src_valid, rounder_valid,
        output rd_en, rd_addr, add_number, keep, rounder_en,
               busy, result_valid, done, err
    );
endinterface

// File: rtl/pe_array_ctrl.sv
// Dot-product pass sequencer for the 2x16 PE array: streams k_len operand
// beats out of the buffers, steers them into the array one cycle later,
// fires the rounder on the last beat and waits for its result.
module pe_array_ctrl #(
    parameter int K_MAX     = 16,
    parameter int ROUND_LAT = 3,
    parameter int TMO       = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    pe_array_ctrl_if.slave bus
);
    localparam int AW   = $clog2(K_MAX);
    localparam int KW   = $clog2(K_MAX + 1);
    localparam int WLIM = ROUND_LAT + TMO;
    localparam int WW   = $clog2(WLIM + 1);

    typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

    state_t        state;
    logic [AW-1:0] beat_cnt;
    logic [KW-1:0] k_len_q;
    logic [2:0]    acc_q;
    logic [WW-1:0] wait_cnt;
    logic [2:0]    add_number;
    logic          keep;
    logic          rounder_en;
    logic          done;
    logic          err;
    logic          rd_en;
    logic          last_beat;

    // Buffer read strobe follows src_valid only while feeding.
    always_comb begin
        rd_en     = (state == FEED) && bus.src_valid;
        last_beat = rd_en && (KW'(beat_cnt) == k_len_q - KW'(1));
    end

    assign bus.rd_en        = rd_en;
    assign bus.rd_addr      = (state == FEED) ? beat_cnt : '0;
    assign bus.add_number   = add_number;
    assign bus.keep         = keep;
    assign bus.rounder_en   = rounder_en;
    assign bus.busy         = (state != IDLE);
    assign bus.result_valid = (state == DRAIN) && bus.rounder_valid;
    assign bus.done         = done;
    assign bus.err          = err;

    // Pass FSM; array-side outputs are registered so that the data read in
    // cycle n is qualified by keep/rounder_en in cycle n+1 (1-cycle buffer
    // latency). keep defaults to 1 so the accumulators hold whenever no beat
    // is arriving, including bubbles from src_valid stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            beat_cnt   <= '0;
            k_len_q    <= '0;
            acc_q      <= '0;
            wait_cnt   <= '0;
            add_number <= '0;
            keep       <= 1'b1;
            rounder_en <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            keep       <= 1'b1;
            rounder_en <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.k_len == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state      <= FEED;
                            k_len_q    <= bus.k_len;
                            acc_q      <= bus.acc_sel;
                            add_number <= bus.acc_sel;
                            beat_cnt   <= '0;
                        end
                    end
                end
                FEED: begin
                    if (rd_en) begin
                        beat_cnt <= beat_cnt + AW'(1);
                        keep     <= 1'b0;
                        if (last_beat) begin
                            state      <= DRAIN;
                            rounder_en <= 1'b1;
                            wait_cnt   <= '0;
                        end
                    end
                end
                DRAIN: begin
                    // A result on the final allowed cycle still counts as success.
                    if (bus.rounder_valid) begin
                        state      <= DONE;
                        done       <= 1'b1;
                        add_number <= '0;
                    end else if (wait_cnt == WW'(WLIM)) begin
                        state      <= DONE;
                        done       <= 1'b1;
                        err        <= 1'b1;
                        add_number <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + WW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // acc_q is kept for visibility of the latched pass parameters.
    logic unused_acc;
    assign unused_acc = ^acc_q;
endmodule

// File: tb/tb_pe_array_ctrl.sv
// Directed, table-driven bench for pe_array_ctrl. Each row holds the inputs
// for one clock cycle and the outputs expected during that same cycle.
module tb_pe_array_ctrl;
    logic clk;
    logic rst_n;

    pe_array_ctrl_if #(.K_MAX(16)) bus ();

    pe_array_ctrl #(.K_MAX(16), .ROUND_LAT(3), .TMO(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic [4:0]  k;
        logic [2:0]  acc;
        logic        sv;
        logic        rv;
        logic [13:0] exp;
    } row_t;

    row_t rows[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // {rd_en, rd_addr[3:0], add_number[2:0], keep, rounder_en, busy, result_valid, done, err}
    function automatic logic [13:0] outs();
        return {bus.rd_en, bus.rd_addr, bus.add_number, bus.keep, bus.rounder_en,
                bus.busy, bus.result_valid, bus.done, bus.err};
    endfunction

    task automatic row(input int st, input int k, input int acc, input int sv, input int rv,
                       input int rd, input int ad, input int an, input int kp, input int re,
                       input int bz, input int rvl, input int dn, input int er);
        row_t r;
        r.start = st[0]; r.k = 5'(k); r.acc = 3'(acc); r.sv = sv[0]; r.rv = rv[0];
        r.exp = {rd[0], 4'(ad), 3'(an), kp[0], re[0], bz[0], rvl[0], dn[0], er[0]};
        rows.push_back(r);
    endtask

    // Idle cycle: any src_valid / rounder_valid must be ignored.
    task automatic idle(input int sv, input int rv);
        row(0, 0, 0, sv, rv, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    endtask

    task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b (rd_en,addr,add_num,keep,ren,busy,rvld,done,err)",
                     name, act, exp);
        end
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            @(posedge clk);
            #1;
            bus.start         = rows[i].start;
            bus.k_len         = rows[i].k;
            bus.acc_sel       = rows[i].acc;
            bus.src_valid     = rows[i].sv;
            bus.rounder_valid = rows[i].rv;
            @(negedge clk);
            check($sformatf("row%0d", i), outs(), rows[i].exp);
        end
    endtask

    task automatic basic(input int busy_start);
        row(1, 4, 5, 1, 0,  0, 0, 0, 1, 0, 0, 0, 0, 0);   // c0 start
        row(0, 0, 0, 1, 0,  1, 0, 5, 1, 0, 1, 0, 0, 0);   // c1
        row(0, 0, 0, 1, 0,  1, 1, 5, 0, 0, 1, 0, 0, 0);   // c2
        row(busy_start, 2, 1, 1, 0,  1, 2, 5, 0, 0, 1, 0, 0, 0);  // c3
        row(0, 0, 0, 1, 0,  1, 3, 5, 0, 0, 1, 0, 0, 0);   // c4
        row(0, 0, 0, 1, 0,  0, 0, 5, 0, 1, 1, 0, 0, 0);   // c5 last beat + rounder_en
        row(0, 0, 0, 1, 0,  0, 0, 5, 1, 0, 1, 0, 0, 0);   // c6
        row(0, 0, 0, 0, 0,  0, 0, 5, 1, 0, 1, 0, 0, 0);   // c7
        row(0, 0, 0, 0, 1,  0, 0, 5, 1, 0, 1, 1, 0, 0);   // c8 result
        row(0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 1, 0, 1, 0);   // c9 done
        idle(0, 0);
    endtask

    int seg_b;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n             = 1'b0;
        bus.start         = 1'b0;
        bus.k_len         = '0;
        bus.acc_sel       = '0;
        bus.src_valid     = 1'b0;
        bus.rounder_valid = 1'b0;

        // Basic pass, then again with an ignored start at c3.
        basic(0);
        idle(1, 1);
        basic(1);
        // Stall: k_len=3, src_valid low on c2.
        row(1, 3, 2, 1, 0,  0, 0, 0, 1, 0, 0, 0, 0, 0);
        row(0, 0, 0, 1, 0,  1, 0, 2, 1, 0, 1, 0, 0, 0);
        row(0, 0, 0, 0, 0,  0, 1, 2, 0, 0, 1, 0, 0, 0);
        row(0, 0, 0, 1, 0,  1, 1, 2, 1, 0, 1, 0, 0, 0);
        row(0, 0, 0, 1, 0,  1, 2, 2, 0, 0, 1, 0, 0, 0);
        row(0, 0, 0, 1, 0,  0, 0, 2, 0, 1, 1, 0, 0, 0);
        row(0, 0, 0, 1, 0,  0, 0, 2, 1, 0, 1, 0, 0, 0);
        row(0, 0, 0, 1, 0,  0, 0, 2, 1, 0, 1, 0, 0, 0);
        row(0, 0, 0, 1, 1,  0, 0, 2, 1, 0, 1, 1, 0, 0);
        row(0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 1, 0, 1, 0);
        idle(0, 0);
        // Zero length.
        row(1, 0, 3, 1, 0,  0, 0, 0, 1, 0, 0, 0, 0, 0);
        row(0, 0, 0, 1, 1,  0, 0, 0, 1, 0, 1, 0, 1, 0);
        idle(1, 0);
        // Timeout: k_len=2, rounder_valid held low.
        row(1, 2, 7, 1, 0,  0, 0, 0, 1, 0, 0, 0, 0, 0);
        row(0, 0, 0, 1, 0,  1, 0, 7, 1, 0, 1, 0, 0, 0);
        row(0, 0, 0, 1, 0,  1, 1, 7, 0, 0, 1, 0, 0, 0);
        row(0, 0, 0, 1, 0,  0, 0, 7, 0, 1, 1, 0, 0, 0);
        for (int c = 4; c <= 10; c++)
            row(0, 0, 0, 1, 0,  0, 0, 7, 1, 0, 1, 0, 0, 0);
        row(0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 1, 0, 1, 1);
        idle(0, 0);

        // Post-reset pass: k_len=1, acc_sel=4.
        seg_b = rows.size();
        row(1, 1, 4, 1, 0,  0, 0, 0, 1, 0, 0, 0, 0, 0);
        row(0, 0, 0, 1, 0,  1, 0, 4, 1, 0, 1, 0, 0, 0);
        row(0, 0, 0, 1, 0,  0, 0, 4, 0, 1, 1, 0, 0, 0);
        row(0, 0, 0, 1, 0,  0, 0, 4, 1, 0, 1, 0, 0, 0);
        row(0, 0, 0, 1, 0,  0, 0, 4, 1, 0, 1, 0, 0, 0);
        row(0, 0, 0, 1, 1,  0, 0, 4, 1, 0, 1, 1, 0, 0);
        row(0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 1, 0, 1, 0);
        idle(0, 0);

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", outs(), 14'b0_0000_000_1_0_0_0_0_0);
        @(negedge clk);
        rst_n = 1'b1;

        run_rows(0, seg_b);

        // Reset mid-FEED of a k_len=8 pass.
        @(posedge clk); #1;
        bus.start = 1'b1; bus.k_len = 5'd8; bus.acc_sel = 3'd6; bus.src_valid = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        check("feed_c2", outs(), {1'b1, 4'd1, 3'd6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", outs(), 14'b0_0000_000_1_0_0_0_0_0);
        @(posedge clk); #1;
        check("reset_held", outs(), 14'b0_0000_000_1_0_0_0_0_0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.src_valid = 1'b0;
        @(negedge clk);
        check("after_release", outs(), 14'b0_0000_000_1_0_0_0_0_0);

        run_rows(seg_b, rows.size());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
